// File: rtl/sprite_if.sv
// sprite_if: plot-path bundle between the movement/rate logic, sprite_engine
// and the VGA adapter plot port. The engine connects through the slave view.
interface sprite_if #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CW = 3
);
  logic          tick;    // one-cycle movement strobe
  logic [3:0]    dir;     // [0] right, [1] up, [2] down, [3] left
  logic [CW-1:0] colour;  // sprite colour
  logic          redraw;  // draw in place, no erase or move
  logic [XW-1:0] x_out;   // pixel x to the adapter
  logic [YW-1:0] y_out;   // pixel y to the adapter
  logic [CW-1:0] c_out;   // pixel colour
  logic          plot;    // pixel write enable
  logic          busy;    // engine not idle
  logic [XW-1:0] x_pos;   // current top-left x
  logic [YW-1:0] y_pos;   // current top-left y

  modport master (
    output tick, dir, colour, redraw,
    input  x_out, y_out, c_out, plot, busy, x_pos, y_pos
  );

  modport slave (
    input  tick, dir, colour, redraw,
    output x_out, y_out, c_out, plot, busy, x_pos, y_pos
  );
endinterface

// File: rtl/sprite_engine.sv
// sprite_engine: single square sprite mover on the VGA plot path.
// Draws a 2^SIZE_LOG2 square at the initial position after reset, and on
// each effective movement tick erases it, steps one pixel per active axis
// (clamped or wrapped at the screen edge) and redraws it. All outputs are
// registered, so a pixel chosen in a state cycle is visible one cycle later.
module sprite_engine #(
  parameter int SIZE_LOG2 = 2,
  parameter int XW        = 8,
  parameter int YW        = 7,
  parameter int X_MAX     = 159,
  parameter int Y_MAX     = 119,
  parameter int X_INIT    = 0,
  parameter int Y_INIT    = 0,
  parameter int CW        = 3,
  parameter int BG        = 0,
  parameter int WRAP      = 0
) (
  input logic      clk,
  input logic      resetn,
  sprite_if.slave  bus
);

  localparam int S    = 1 << SIZE_LOG2;
  localparam int CNTW = 2 * SIZE_LOG2;

  // Highest legal top-left coordinate so the whole sprite stays on screen.
  localparam logic [XW-1:0]   XLIM_C   = XW'(X_MAX - S + 1);
  localparam logic [YW-1:0]   YLIM_C   = YW'(Y_MAX - S + 1);
  localparam logic [XW-1:0]   X_INIT_C = XW'(X_INIT);
  localparam logic [YW-1:0]   Y_INIT_C = YW'(Y_INIT);
  localparam logic [XW-1:0]   X_ONE    = XW'(1);
  localparam logic [YW-1:0]   Y_ONE    = YW'(1);
  localparam logic [XW-1:0]   X_ZERO   = XW'(0);
  localparam logic [YW-1:0]   Y_ZERO   = YW'(0);
  localparam logic [CW-1:0]   BG_C     = CW'(BG);
  localparam logic [CW-1:0]   C_ZERO   = CW'(0);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_ZERO = CNTW'(0);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'((S * S) - 1);
  localparam bit              WRAP_C   = (WRAP != 0);

  typedef enum logic [1:0] {
    ST_DRAW  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ERASE = 2'd2,
    ST_MOVE  = 2'd3
  } state_t;

  // One-pixel step on x: inc/dec cancel when both set; edges clamp or wrap.
  function automatic logic [XW-1:0] step_x(input logic [XW-1:0] p,
                                           input logic inc,
                                           input logic dec);
    logic [XW-1:0] r;
    r = p;
    if (inc && !dec) begin
      if (p == XLIM_C) begin
        r = WRAP_C ? X_ZERO : p;
      end else begin
        r = p + X_ONE;
      end
    end else if (dec && !inc) begin
      if (p == X_ZERO) begin
        r = WRAP_C ? XLIM_C : p;
      end else begin
        r = p - X_ONE;
      end
    end else begin
      r = p;
    end
    return r;
  endfunction

  // One-pixel step on y, same edge rule as x.
  function automatic logic [YW-1:0] step_y(input logic [YW-1:0] p,
                                           input logic inc,
                                           input logic dec);
    logic [YW-1:0] r;
    r = p;
    if (inc && !dec) begin
      if (p == YLIM_C) begin
        r = WRAP_C ? Y_ZERO : p;
      end else begin
        r = p + Y_ONE;
      end
    end else if (dec && !inc) begin
      if (p == Y_ZERO) begin
        r = WRAP_C ? YLIM_C : p;
      end else begin
        r = p - Y_ONE;
      end
    end else begin
      r = p;
    end
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;         // {oy, ox} raster offset
  logic [XW-1:0]   x_q, x_d;             // top-left position
  logic [YW-1:0]   y_q, y_d;
  logic [XW-1:0]   cand_x_q, cand_x_d;   // position to load in MOVE
  logic [YW-1:0]   cand_y_q, cand_y_d;
  logic [CW-1:0]   col_q, col_d;         // latched sprite colour
  logic [XW-1:0]   x_out_q, x_out_d;
  logic [YW-1:0]   y_out_q, y_out_d;
  logic [CW-1:0]   c_out_q, c_out_d;
  logic            plot_q, plot_d;
  logic            busy_q, busy_d;

  logic [XW-1:0]   pix_x_s;
  logic [YW-1:0]   pix_y_s;
  logic [XW-1:0]   nx_s;
  logic [YW-1:0]   ny_s;
  logic            moved_s;

  // Current pixel address and the candidate step from the live direction.
  always_comb begin
    pix_x_s = x_q + XW'(cnt_q[SIZE_LOG2-1:0]);
    pix_y_s = y_q + YW'(cnt_q[CNTW-1:SIZE_LOG2]);
    nx_s    = step_x(x_q, bus.dir[0], bus.dir[3]);
    ny_s    = step_y(y_q, bus.dir[2], bus.dir[1]);
    moved_s = (nx_s != x_q) || (ny_s != y_q);
  end

  // Next-state, datapath and registered-output decode for the sprite FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = x_q;
    y_d      = y_q;
    cand_x_d = cand_x_q;
    cand_y_d = cand_y_q;
    col_d    = col_q;
    x_out_d  = x_out_q;
    y_out_d  = y_out_q;
    c_out_d  = c_out_q;
    plot_d   = 1'b0;

    case (state_q)
      ST_ERASE, ST_DRAW: begin
        plot_d  = 1'b1;
        x_out_d = pix_x_s;
        y_out_d = pix_y_s;
        c_out_d = (state_q == ST_ERASE) ? BG_C : col_q;
        // Counter is exactly N wide in range, so +1 at N-1 wraps to 0.
        cnt_d   = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = (state_q == ST_ERASE) ? ST_MOVE : ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      ST_IDLE: begin
        if (bus.tick) begin
          col_d = bus.colour;
        end else if (bus.redraw) begin
          col_d = bus.colour;
        end else begin
          col_d = col_q;
        end
        // An effective tick beats a simultaneous redraw; a tick that would
        // not change the position is ignored to avoid a pointless flicker.
        if (bus.tick && moved_s) begin
          cand_x_d = nx_s;
          cand_y_d = ny_s;
          state_d  = ST_ERASE;
        end else if (bus.redraw) begin
          state_d  = ST_DRAW;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_MOVE: begin
        x_d     = cand_x_q;
        y_d     = cand_y_q;
        state_d = ST_DRAW;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_DRAW;
      cnt_q    <= CNT_ZERO;
      x_q      <= X_INIT_C;
      y_q      <= Y_INIT_C;
      cand_x_q <= X_INIT_C;
      cand_y_q <= Y_INIT_C;
      col_q    <= bus.colour;
      x_out_q  <= X_INIT_C;
      y_out_q  <= Y_INIT_C;
      c_out_q  <= C_ZERO;
      plot_q   <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cand_x_q <= cand_x_d;
      cand_y_q <= cand_y_d;
      col_q    <= col_d;
      x_out_q  <= x_out_d;
      y_out_q  <= y_out_d;
      c_out_q  <= c_out_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.x_out = x_out_q;
  assign bus.y_out = y_out_q;
  assign bus.c_out = c_out_q;
  assign bus.plot  = plot_q;
  assign bus.busy  = busy_q;
  assign bus.x_pos = x_q;
  assign bus.y_pos = y_q;

endmodule

// File: tb/tb_sprite_engine.sv
// tb_sprite_engine: two engines (A: clamp, start 10,20; B: wrap, start 0,0)
// checked every cycle against a schedule-based reference model, plus a
// vector table and hand-written corner sequences.
module tb_sprite_engine;
  localparam int S    = 4;
  localparam int N    = 16;
  localparam int XLIM = 156;
  localparam int YLIM = 116;
  localparam int RW   = 128;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn_v[2];
  logic       tick_v[2];
  logic [3:0] dir_v[2];
  logic [2:0] col_v[2];
  logic       redraw_v[2];

  sprite_if #(.XW(8), .YW(7), .CW(3)) ifa ();
  sprite_if #(.XW(8), .YW(7), .CW(3)) ifb ();

  assign ifa.tick   = tick_v[0];
  assign ifa.dir    = dir_v[0];
  assign ifa.colour = col_v[0];
  assign ifa.redraw = redraw_v[0];
  assign ifb.tick   = tick_v[1];
  assign ifb.dir    = dir_v[1];
  assign ifb.colour = col_v[1];
  assign ifb.redraw = redraw_v[1];

  sprite_engine #(.SIZE_LOG2(2), .XW(8), .YW(7), .X_MAX(159), .Y_MAX(119),
                  .X_INIT(10), .Y_INIT(20), .CW(3), .BG(0), .WRAP(0))
    dut_a (.clk(clk), .resetn(rstn_v[0]), .bus(ifa));

  sprite_engine #(.SIZE_LOG2(2), .XW(8), .YW(7), .X_MAX(159), .Y_MAX(119),
                  .X_INIT(0), .Y_INIT(0), .CW(3), .BG(0), .WRAP(1))
    dut_b (.clk(clk), .resetn(rstn_v[1]), .bus(ifb));

  logic [7:0] ax_out[2], ax_pos[2];
  logic [6:0] ay_out[2], ay_pos[2];
  logic [2:0] ac_out[2];
  logic       aplot[2], abusy[2];
  assign ax_out[0] = ifa.x_out;  assign ax_out[1] = ifb.x_out;
  assign ay_out[0] = ifa.y_out;  assign ay_out[1] = ifb.y_out;
  assign ac_out[0] = ifa.c_out;  assign ac_out[1] = ifb.c_out;
  assign aplot[0]  = ifa.plot;   assign aplot[1]  = ifb.plot;
  assign abusy[0]  = ifa.busy;   assign abusy[1]  = ifb.busy;
  assign ax_pos[0] = ifa.x_pos;  assign ax_pos[1] = ifb.x_pos;
  assign ay_pos[0] = ifa.y_pos;  assign ay_pos[1] = ifb.y_pos;

  // Reference model state: sprite position, when the engine is free again,
  // and a per-cycle schedule of what must be visible on the outputs.
  int xi[2] = '{10, 0};
  int yi[2] = '{20, 0};
  bit wr[2] = '{1'b0, 1'b1};
  int mx[2], my[2], free_at[2];
  int shx[2], shy[2], pdx[2], pdy[2], pdt[2];
  bit armed[2];
  bit e_plot[2][RW], e_busy[2][RW], e_rst[2][RW];
  int e_x[2][RW], e_y[2][RW], e_c[2][RW];
  int cyc, n_cmp, n_bad;
  int plot_cnt[2];

  typedef struct {
    int         d;
    logic [3:0] dir;
    bit         tk;
    bit         rd;
    logic [2:0] col;
    int         ex;
    int         ey;
    int         eplots;
  } vec_t;
  vec_t tv[12];

  task automatic cmp(input int d, input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s.%s cyc=%0d got=%0d want=%0d", (d == 0) ? "A" : "B", nm, cyc, act, exp);
    end
  endtask

  function automatic int mstep(input int p, input int dlt, input int lim, input bit w);
    int r;
    r = p + dlt;
    if (r < 0) r = w ? lim : 0;
    else if (r > lim) r = w ? 0 : lim;
    return r;
  endfunction

  // One full sprite pass: pixels in raster order, first one visible at t0.
  task automatic sched_pass(input int d, input int t0, input int px, input int py, input int c);
    for (int k = 0; k < N; k++) begin
      e_plot[d][(t0 + k) % RW] = 1'b1;
      e_x[d][(t0 + k) % RW]    = px + (k % S);
      e_y[d][(t0 + k) % RW]    = py + (k / S);
      e_c[d][(t0 + k) % RW]    = c;
    end
  endtask

  task automatic sched_busy(input int d, input int a, input int b);
    for (int t = a; t <= b; t++) e_busy[d][t % RW] = 1'b1;
  endtask

  // Apply the behavioural rules to the inputs sampled at edge E = cyc.
  task automatic model_edge(input int d);
    int e, nx, ny;
    e = cyc;
    if (!rstn_v[d]) begin
      for (int i = 0; i < RW; i++) begin
        e_plot[d][i] = 1'b0; e_busy[d][i] = 1'b0; e_rst[d][i] = 1'b0;
      end
      armed[d] = 1'b1;
      mx[d] = xi[d]; my[d] = yi[d];
      e_rst[d][(e + 1) % RW] = 1'b1;
      sched_pass(d, e + 2, xi[d], yi[d], int'(col_v[d]));
      sched_busy(d, e + 1, e + N);
      free_at[d] = e + N + 1;
      pdx[d] = xi[d]; pdy[d] = yi[d]; pdt[d] = e + 1;
    end else if (armed[d] && e >= free_at[d]) begin
      nx = mstep(mx[d], (dir_v[d][0] ? 1 : 0) - (dir_v[d][3] ? 1 : 0), XLIM, wr[d]);
      ny = mstep(my[d], (dir_v[d][2] ? 1 : 0) - (dir_v[d][1] ? 1 : 0), YLIM, wr[d]);
      if (tick_v[d] && (nx != mx[d] || ny != my[d])) begin
        sched_pass(d, e + 2, mx[d], my[d], 0);
        sched_pass(d, e + N + 3, nx, ny, int'(col_v[d]));
        sched_busy(d, e + 1, e + 2 * N + 1);
        pdx[d] = nx; pdy[d] = ny; pdt[d] = e + N + 2;
        mx[d] = nx; my[d] = ny;
        free_at[d] = e + 2 * N + 2;
      end else if (redraw_v[d]) begin
        sched_pass(d, e + 2, mx[d], my[d], int'(col_v[d]));
        sched_busy(d, e + 1, e + N);
        free_at[d] = e + N + 1;
      end
    end
  endtask

  // Compare everything visible in the current cycle against the schedule.
  task automatic check(input int d);
    int idx;
    if (!armed[d]) return;
    idx = cyc % RW;
    if (pdt[d] >= 0 && cyc >= pdt[d]) begin
      shx[d] = pdx[d]; shy[d] = pdy[d]; pdt[d] = -1;
    end
    if (e_rst[d][idx]) begin
      cmp(d, "rst_plot", int'(aplot[d]), 0);
      cmp(d, "rst_busy", int'(abusy[d]), 1);
      cmp(d, "rst_x_out", int'(ax_out[d]), xi[d]);
      cmp(d, "rst_y_out", int'(ay_out[d]), yi[d]);
      cmp(d, "rst_c_out", int'(ac_out[d]), 0);
    end else begin
      cmp(d, "plot", int'(aplot[d]), int'(e_plot[d][idx]));
      cmp(d, "busy", int'(abusy[d]), int'(e_busy[d][idx]));
      if (e_plot[d][idx]) begin
        cmp(d, "x_out", int'(ax_out[d]), e_x[d][idx]);
        cmp(d, "y_out", int'(ay_out[d]), e_y[d][idx]);
        cmp(d, "c_out", int'(ac_out[d]), e_c[d][idx]);
      end
    end
    cmp(d, "x_pos", int'(ax_pos[d]), shx[d]);
    cmp(d, "y_pos", int'(ay_pos[d]), shy[d]);
    if (aplot[d]) plot_cnt[d]++;
    e_plot[d][idx] = 1'b0; e_busy[d][idx] = 1'b0; e_rst[d][idx] = 1'b0;
  endtask

  task automatic step();
    model_edge(0);
    model_edge(1);
    @(posedge clk);
    #1;
    cyc++;
    check(0);
    check(1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse(input int d, input logic [3:0] dr, input bit tk, input bit rd,
                       input logic [2:0] c);
    dir_v[d] = dr; tick_v[d] = tk; redraw_v[d] = rd; col_v[d] = c;
    step();
    tick_v[d] = 1'b0; redraw_v[d] = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    for (int d = 0; d < 2; d++) begin
      armed[d] = 1'b0; free_at[d] = 0; pdt[d] = -1; plot_cnt[d] = 0;
      rstn_v[d] = 1'b0; tick_v[d] = 1'b0; redraw_v[d] = 1'b0; dir_v[d] = 4'd0;
    end
    col_v[0] = 3'd4; col_v[1] = 3'd5;

    // Reset and initial draw.
    run(2);
    rstn_v[0] = 1'b1; rstn_v[1] = 1'b1;
    run(20);
    cmp(0, "init_plots", plot_cnt[0], 16);
    cmp(0, "init_xpos", int'(ax_pos[0]), 10);
    cmp(0, "init_ypos", int'(ay_pos[0]), 20);
    cmp(1, "init_plots", plot_cnt[1], 16);

    // Vector table: single moves, cancellations, redraw, wrap edges.
    tv[0]  = '{0, 4'b0001, 1'b1, 1'b0, 3'd4, 11, 20, 32};
    tv[1]  = '{0, 4'b1011, 1'b1, 1'b0, 3'd4, 11, 19, 32};
    tv[2]  = '{0, 4'b1001, 1'b1, 1'b0, 3'd4, 11, 19, 0};
    tv[3]  = '{0, 4'b0110, 1'b1, 1'b0, 3'd4, 11, 19, 0};
    tv[4]  = '{0, 4'b0000, 1'b0, 1'b1, 3'd2, 11, 19, 16};
    tv[5]  = '{0, 4'b1000, 1'b1, 1'b1, 3'd6, 10, 19, 32};
    tv[6]  = '{1, 4'b1010, 1'b1, 1'b0, 3'd3, 156, 116, 32};
    tv[7]  = '{1, 4'b0101, 1'b1, 1'b0, 3'd7, 0, 0, 32};
    tv[8]  = '{1, 4'b1000, 1'b1, 1'b0, 3'd1, 156, 0, 32};
    tv[9]  = '{1, 4'b0011, 1'b1, 1'b0, 3'd2, 0, 116, 32};
    tv[10] = '{0, 4'b0000, 1'b1, 1'b1, 3'd1, 10, 19, 16};
    tv[11] = '{0, 4'b0100, 1'b1, 1'b0, 3'd5, 10, 20, 32};
    for (int i = 0; i < 12; i++) begin
      plot_cnt[tv[i].d] = 0;
      pulse(tv[i].d, tv[i].dir, tv[i].tk, tv[i].rd, tv[i].col);
      run(40);
      cmp(tv[i].d, $sformatf("vec%0d_x", i), int'(ax_pos[tv[i].d]), tv[i].ex);
      cmp(tv[i].d, $sformatf("vec%0d_y", i), int'(ay_pos[tv[i].d]), tv[i].ey);
      cmp(tv[i].d, $sformatf("vec%0d_plots", i), plot_cnt[tv[i].d], tv[i].eplots);
    end

    // Randomised traffic on both engines, including rare resets.
    for (int i = 0; i < 3000; i++) begin
      for (int d = 0; d < 2; d++) begin
        tick_v[d]   = ($urandom_range(0, 3) == 0);
        dir_v[d]    = 4'($urandom_range(0, 15));
        col_v[d]    = 3'($urandom_range(0, 7));
        redraw_v[d] = ($urandom_range(0, 9) == 0);
        rstn_v[d]   = ($urandom_range(0, 499) != 0);
      end
      step();
    end
    for (int d = 0; d < 2; d++) begin
      tick_v[d] = 1'b0; redraw_v[d] = 1'b0; rstn_v[d] = 1'b1;
    end
    run(40);

    // Walk A diagonally into the bottom-right clamp corner.
    for (int i = 0; i < 400; i++) begin
      if (mx[0] == XLIM && my[0] == YLIM) break;
      pulse(0, 4'b0101, 1'b1, 1'b0, 3'd4);
      run(40);
    end
    cmp(0, "corner_x", int'(ax_pos[0]), 156);
    cmp(0, "corner_y", int'(ay_pos[0]), 116);
    plot_cnt[0] = 0;
    pulse(0, 4'b0101, 1'b1, 1'b0, 3'd4);
    run(40);
    cmp(0, "clamp_plots", plot_cnt[0], 0);
    cmp(0, "clamp_x", int'(ax_pos[0]), 156);
    plot_cnt[0] = 0;
    pulse(0, 4'b1000, 1'b1, 1'b0, 3'd4);
    run(40);
    cmp(0, "left_x", int'(ax_pos[0]), 155);
    cmp(0, "left_plots", plot_cnt[0], 32);

    // A second tick during ERASE is dropped: exactly one move.
    plot_cnt[0] = 0;
    pulse(0, 4'b0010, 1'b1, 1'b0, 3'd4);
    run(5);
    pulse(0, 4'b1000, 1'b1, 1'b0, 3'd4);
    run(40);
    cmp(0, "drop_x", int'(ax_pos[0]), 155);
    cmp(0, "drop_y", int'(ay_pos[0]), 115);
    cmp(0, "drop_plots", plot_cnt[0], 32);

    // Reset while draw pixel 7 is being emitted, then redraw in place.
    pulse(0, 4'b1000, 1'b1, 1'b0, 3'd3);
    run(24);
    rstn_v[0] = 1'b0;
    step();
    rstn_v[0] = 1'b1;
    cmp(0, "midrst_plot", int'(aplot[0]), 0);
    plot_cnt[0] = 0;
    run(25);
    cmp(0, "midrst_plots", plot_cnt[0], 16);
    cmp(0, "midrst_x", int'(ax_pos[0]), 10);
    cmp(0, "midrst_y", int'(ay_pos[0]), 20);
    plot_cnt[0] = 0;
    pulse(0, 4'b0000, 1'b0, 1'b1, 3'd2);
    run(25);
    cmp(0, "redraw_plots", plot_cnt[0], 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
